axis_write_cmd: RTL

Command sequencer for the AXI write path: accepts one transfer command (start address, length in stream words), configures `axis_write_data` with the length, and splits the transfer into AXI write-address bursts that never cross a `BURST_MAX`-beat alignment boundary. It also tracks outstanding write responses and signals completion once every burst is acknowledged and the data unit reports done. It sits between the configuration register bank and the AXI AW/B channels, alongside `axis_write_data`, which owns the W channel.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_write_cmd.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI write command path: FSM encoding, response codes
// and the boundary-aware burst sizing helper.
package axis_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CONFIG = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Largest burst that neither exceeds the remaining beats nor crosses a burst_max-beat boundary.
    function automatic logic [31:0] burst_beats(input logic [31:0] beats_rem,
                                                input logic [31:0] beat_addr,
                                                input logic [31:0] burst_max);
        logic [31:0] room;
        room = burst_max - (beat_addr & (burst_max - 32'd1));
        return (beats_rem < room) ? beats_rem : room;
    endfunction

endpackage

// File: rtl/axis_write_cmd.sv
// AXI write command sequencer: configures the data unit, splits a transfer into
// boundary-aligned AW bursts and tracks outstanding B responses until completion.
module axis_write_cmd
    import axis_pkg::*;
#(
    parameter int CONFIG_DWIDTH   = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 8,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int WIDTH_RATIO     = 8,
    parameter int BURST_MAX       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_address,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [CONFIG_DWIDTH-1:0]  data_cfg_length,
    output logic                      data_cfg_valid,
    input  logic                      data_done,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready
);

    localparam int BYTES       = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT  = $clog2(BYTES);
    localparam int RATIO_SHIFT = $clog2(WIDTH_RATIO);
    localparam int OW          = $clog2(MAX_OUTSTANDING + 1);

    logic [2:0]                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CONFIG_DWIDTH-1:0]  beats_q, beats_d;
    logic [CONFIG_DWIDTH-1:0]  len_q, len_d;
    logic [AXI_LEN_WIDTH-1:0]  awlen_q, awlen_d;
    logic [OW-1:0]             outst_q, outst_d;
    logic                      error_q, error_d;
    logic                      dds_q, dds_d;

    logic                      aw_hs, b_hs;
    logic [31:0]               burst_cur, burst_next, burst_first;
    logic [CONFIG_DWIDTH-1:0]  cfg_beats, beats_after;
    logic [AXI_ADDR_WIDTH-1:0] addr_after;

    assign aw_hs = axi_awvalid & axi_awready;
    assign b_hs  = axi_bvalid & axi_bready;

    // Round up: a partial final AXI beat still costs a full beat.
    assign cfg_beats = (cfg_length >> RATIO_SHIFT)
                     + CONFIG_DWIDTH'(|(cfg_length & CONFIG_DWIDTH'(WIDTH_RATIO - 1)));

    // The presented burst length lives in awlen_q, so the post-handshake pointers need no re-sizing.
    assign burst_cur   = 32'(awlen_q) + 32'd1;
    assign beats_after = beats_q - CONFIG_DWIDTH'(burst_cur);
    assign addr_after  = addr_q + AXI_ADDR_WIDTH'(burst_cur << BYTE_SHIFT);
    assign burst_first = burst_beats(32'(beats_q), 32'(addr_q >> BYTE_SHIFT), 32'(BURST_MAX));
    assign burst_next  = burst_beats(32'(beats_after), 32'(addr_after >> BYTE_SHIFT), 32'(BURST_MAX));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        len_d   = len_q;
        awlen_d = awlen_q;
        outst_d = outst_q;
        error_d = error_q;
        dds_d   = dds_q;

        if (b_hs && (axi_bresp != RESP_OKAY)) error_d = 1'b1;
        if (data_done && (state_q != ST_IDLE)) dds_d = 1'b1;

        case ({aw_hs, b_hs})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    addr_d  = AXI_ADDR_WIDTH'(cfg_address);
                    len_d   = cfg_length;
                    beats_d = cfg_beats;
                    error_d = 1'b0;
                    dds_d   = 1'b0;
                    state_d = (cfg_length == '0) ? ST_DONE : ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                awlen_d = AXI_LEN_WIDTH'(burst_first - 32'd1);
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (aw_hs) begin
                    addr_d  = addr_after;
                    beats_d = beats_after;
                    awlen_d = (burst_next == 32'd0) ? '0 : AXI_LEN_WIDTH'(burst_next - 32'd1);
                    if (beats_after == '0) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Next-state values let done follow the final event by exactly one cycle.
                if ((outst_d == '0) && dds_d) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            len_q   <= '0;
            awlen_q <= '0;
            outst_q <= '0;
            error_q <= 1'b0;
            dds_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            len_q   <= len_d;
            awlen_q <= awlen_d;
            outst_q <= outst_d;
            error_q <= error_d;
            dds_q   <= dds_d;
        end
    end

    assign cfg_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign error           = error_q;
    assign data_cfg_valid  = (state_q == ST_CONFIG);
    assign data_cfg_length = (state_q == ST_CONFIG) ? len_q : '0;
    assign axi_awaddr      = addr_q;
    assign axi_awlen       = awlen_q;
    assign axi_awvalid     = (state_q == ST_ADDR) && (outst_q != OW'(MAX_OUTSTANDING));
    assign axi_bready      = ((state_q == ST_ADDR) || (state_q == ST_WAIT)) && (outst_q != '0);

endmodule
